// File: rtl/noc_output_arbiter.sv
// Output-port arbiter for the mesh router: round-robin grant among input FIFOs,
// wormhole-locked until the owning packet's tail flit has been forwarded.
//  state | meaning
//  IDLE  | no owner; pick next eligible head flit starting at rr_ptr
//  LOCK  | grant_idx owns the output; forward its flits until tail/single
module noc_output_arbiter #(
  parameter int WIDTH  = 18,
  parameter int NPORTS = 5,
  parameter int PTR_W  = $clog2(NPORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         fifo_empty,
  input  logic [NPORTS-1:0]         route_req,
  input  logic [NPORTS*WIDTH-1:0]   fifo_data,
  output logic [NPORTS-1:0]         fifo_read,
  input  logic                      out_full,
  output logic                      out_write,
  output logic [WIDTH-1:0]          out_flit,
  output logic                      grant_valid,
  output logic [PTR_W-1:0]          grant_idx,
  output logic                      err
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic               err_q, err_d;
  logic               first_q, first_d;

  logic [NPORTS-1:0]  elig;
  logic [NPORTS-1:0]  bad_req;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [WIDTH-1:0]   flit_sel;
  logic               empty_sel;
  logic               locked;
  logic               xfer;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NPORTS) s = s - NPORTS;
    return PTR_W'(s);
  endfunction

  // Type bit WIDTH-2 marks a packet start (head/single), bit WIDTH-1 a packet end (tail/single).
  always_comb begin
    elig    = '0;
    bad_req = '0;
    for (int i = 0; i < NPORTS; i++) begin
      elig[i]    = route_req[i] & ~fifo_empty[i] &  fifo_data[i*WIDTH + WIDTH-2];
      bad_req[i] = route_req[i] & ~fifo_empty[i] & ~fifo_data[i*WIDTH + WIDTH-2];
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (!found && elig[wrap_inc(rr_ptr_q, k)]) begin
        found = 1'b1;
        pick  = wrap_inc(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    flit_sel  = '0;
    empty_sel = 1'b1;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant_idx_q == PTR_W'(i)) begin
        flit_sel  = fifo_data[i*WIDTH +: WIDTH];
        empty_sel = fifo_empty[i];
      end
    end
  end

  assign locked = (state_q == LOCK);
  assign xfer   = locked & ~empty_sel & ~out_full;

  always_comb begin
    fifo_read = '0;
    for (int i = 0; i < NPORTS; i++) begin
      fifo_read[i] = xfer && (grant_idx_q == PTR_W'(i));
    end
  end

  assign out_write   = xfer;
  assign out_flit    = locked ? flit_sel : '0;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign err         = err_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    err_d         = err_q;
    first_d       = first_q;
    case (state_q)
      IDLE: begin
        if (|bad_req) err_d = 1'b1;
        if (found) begin
          grant_idx_d   = pick;
          grant_valid_d = 1'b1;
          first_d       = 1'b1;
          state_d       = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          first_d = 1'b0;
          // A new packet start inside a locked packet is a protocol error but still forwarded.
          if (flit_sel[WIDTH-2] && !first_q) err_d = 1'b1;
          if (flit_sel[WIDTH-1]) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            rr_ptr_d      = wrap_inc(grant_idx_q, 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      err_q         <= 1'b0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      err_q         <= err_d;
      first_q       <= first_d;
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: FIFO models per input port and a
// scoreboard of flits expected on the output, in expected grant order.
module tb_noc_output_arbiter;
  localparam int WIDTH  = 18;
  localparam int NPORTS = 5;
  localparam int PTR_W  = 3;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NPORTS-1:0]       fifo_empty;
  logic [NPORTS-1:0]       route_req;
  logic [NPORTS*WIDTH-1:0] fifo_data;
  logic [NPORTS-1:0]       fifo_read;
  logic                    out_full;
  logic                    out_write;
  logic [WIDTH-1:0]        out_flit;
  logic                    grant_valid;
  logic [PTR_W-1:0]        grant_idx;
  logic                    err;

  logic [WIDTH-1:0] fq [NPORTS][$];
  logic [WIDTH-1:0] exp_flit [$];
  int               exp_port [$];
  logic [NPORTS-1:0] route_en;
  logic [NPORTS-1:0] hold_empty;
  logic [NPORTS-1:0] rd_cap;
  int               order [6];
  int               errors = 0;
  int               checks = 0;

  noc_output_arbiter #(.WIDTH(WIDTH), .NPORTS(NPORTS), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .route_req(route_req),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .out_full(out_full),
    .out_write(out_write), .out_flit(out_flit), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NPORTS; i++) begin
      fifo_empty[i] = (fq[i].size() == 0) | hold_empty[i];
      fifo_data[i*WIDTH +: WIDTH] = (fq[i].size() != 0) ? fq[i][0] : '0;
      route_req[i] = route_en[i];
    end
  endtask

  task automatic push(input int p, input logic [1:0] t, input int seq, input bit expect_out);
    logic [WIDTH-1:0] f;
    f = {t, 8'(p), 8'(seq)};
    fq[p].push_back(f);
    if (expect_out) begin
      exp_flit.push_back(f);
      exp_port.push_back(p);
    end
  endtask

  // FIFO model: pops what the DUT read at the edge, then re-presents front flits.
  initial begin
    logic [WIDTH-1:0] dummy;
    rd_cap = '0;
    route_en = '0;
    hold_empty = '0;
    refresh();
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        for (int i = 0; i < NPORTS; i++) begin
          if (rd_cap[i] && fq[i].size() != 0) dummy = fq[i].pop_front();
        end
      end
      refresh();
      @(negedge clk); #1;
      refresh();
    end
  end

  // Scoreboard: every downstream write must match the next expected flit and owner.
  initial begin
    logic [WIDTH-1:0] ef;
    int ep;
    forever begin
      @(negedge clk); #2;
      rd_cap = fifo_read;
      if (out_write) begin
        if (exp_flit.size() == 0) begin
          check("sb_unexpected_write", out_write, 0);
        end else begin
          ef = exp_flit.pop_front();
          ep = exp_port.pop_front();
          check("sb_flit", out_flit, ef);
          check("sb_read", fifo_read, 32'(1) << ep);
          check("sb_gidx", grant_idx, ep);
        end
      end else begin
        check("sb_idle_read", fifo_read, 0);
      end
    end
  end

  initial begin
    order = '{0, 1, 4, 0, 1, 4};
    rst = 1'b0;
    out_full = 1'b0;
    #2;
    check("rst_gv", grant_valid, 0);
    check("rst_gidx", grant_idx, 0);
    check("rst_err", err, 0);
    check("rst_write", out_write, 0);
    check("rst_read", fifo_read, 0);
    check("rst_flit", out_flit, 0);
    @(negedge clk); rst = 1'b1;

    // Single 3-flit packet from port 2
    @(negedge clk);
    push(2, T_HEAD, 0, 1); push(2, T_BODY, 1, 1); push(2, T_TAIL, 2, 1);
    route_en = 5'b00100;
    check("t1_gv_before", grant_valid, 0);
    @(negedge clk);
    check("t1_gv", grant_valid, 1);
    check("t1_gidx", grant_idx, 2);
    check("t1_read", fifo_read, 5'b00100);
    check("t1_head_write", out_write, 1);
    @(negedge clk); check("t1_body_write", out_write, 1);
    @(negedge clk); check("t1_tail_write", out_write, 1);
    @(negedge clk);
    check("t1_gv_drop", grant_valid, 0);
    check("t1_gap", out_write, 0);
    check("t1_rr", dut.rr_ptr_q, 3);
    route_en = '0;

    // Wormhole lock: port 3 owns, port 0 requests mid-packet
    push(3, T_HEAD, 0, 1); push(3, T_BODY, 1, 1); push(3, T_BODY, 2, 1); push(3, T_TAIL, 3, 1);
    route_en = 5'b01000;
    @(negedge clk);
    check("t3_gidx", grant_idx, 3);
    check("t3_write", out_write, 1);
    push(0, T_SINGLE, 0, 1);
    route_en = 5'b01001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_gidx", grant_idx, 3);
      check("t3_hold_write", out_write, 1);
    end
    @(negedge clk);
    check("t3_bubble_write", out_write, 0);
    check("t3_bubble_gv", grant_valid, 0);
    @(negedge clk);
    check("t3_p0_gidx", grant_idx, 0);
    check("t3_p0_gv", grant_valid, 1);
    check("t3_p0_write", out_write, 1);
    @(negedge clk);
    check("t3_rr_wrap", dut.rr_ptr_q, 1);
    check("t3_gv_drop", grant_valid, 0);
    route_en = '0;

    // Backpressure then source starvation mid-packet on port 1
    push(1, T_HEAD, 0, 1); push(1, T_BODY, 1, 1); push(1, T_BODY, 2, 1);
    push(1, T_BODY, 3, 1); push(1, T_TAIL, 4, 1);
    route_en = 5'b00010;
    @(negedge clk);
    check("t4_head_write", out_write, 1);
    check("t4_gidx", grant_idx, 1);
    @(negedge clk);
    check("t4_b1_ready", out_write, 1);
    out_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_full_write", out_write, 0);
      check("t4_full_read", fifo_read, 0);
      check("t4_full_gv", grant_valid, 1);
    end
    out_full = 1'b0;
    hold_empty = 5'b00010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_empty_write", out_write, 0);
      check("t4_empty_read", fifo_read, 0);
      check("t4_empty_gv", grant_valid, 1);
    end
    hold_empty = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_resume_write", out_write, 1);
    end
    @(negedge clk);
    check("t4_done_gv", grant_valid, 0);
    check("t4_sb_drained", exp_flit.size(), 0);
    route_en = '0;

    // Protocol error: body flit at front of a requesting port in IDLE
    check("t5_err_before", err, 0);
    push(1, T_BODY, 9, 0);
    route_en = 5'b00010;
    @(negedge clk);
    check("t5_err_set", err, 1);
    check("t5_no_grant", grant_valid, 0);
    @(negedge clk);
    check("t5_no_grant2", grant_valid, 0);
    check("t5_no_write", out_write, 0);
    fq[1].delete();
    route_en = '0;
    @(negedge clk);
    check("t5_sticky", err, 1);

    // Asynchronous reset in the middle of a port-4 packet
    push(4, T_HEAD, 0, 1); push(4, T_BODY, 1, 1); push(4, T_BODY, 2, 1); push(4, T_TAIL, 3, 1);
    route_en = 5'b10000;
    @(negedge clk);
    check("t6_gidx", grant_idx, 4);
    check("t6_write1", out_write, 1);
    @(negedge clk);
    check("t6_write2", out_write, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6_rst_gv", grant_valid, 0);
    check("t6_rst_read", fifo_read, 0);
    check("t6_rst_write", out_write, 0);
    check("t6_rst_flit", out_flit, 0);
    check("t6_sb_left", exp_flit.size(), 2);
    fq[4].delete();
    exp_flit.delete();
    exp_port.delete();
    route_en = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_rel_gv", grant_valid, 0);
    check("t6_rel_err", err, 0);
    check("t6_rel_rr", dut.rr_ptr_q, 0);
    check("t6_rel_write", out_write, 0);

    // Round-robin fairness among ports 0, 1, 4 offering single-flit packets
    for (int r = 0; r < 2; r++) begin
      push(0, T_SINGLE, r, 1);
      push(1, T_SINGLE, r, 1);
      push(4, T_SINGLE, r, 1);
    end
    route_en = 5'b10011;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t2_write_pattern", out_write, (k % 2 == 0));
      if (k % 2 == 0) check("t2_order", grant_idx, order[k/2]);
    end
    check("t2_sb_drained", exp_flit.size(), 0);
    route_en = '0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port packet arbiter for the 4x4 mesh router.
- Shares one output channel among N input-port FIFOs (N, E, S, W, Local) using round-robin arbitration with wormhole locking.
- Once granted, an input keeps the channel until its tail flit transfers.
- Drives the FIFO read strobes on the input side and the write strobe of the downstream FIFO or link.

Parameters:
- WIDTH, 18, flit width. Bits [WIDTH-1:WIDTH-2] hold the flit type: 01 head, 00 body, 10 tail, 11 single (head+tail).
- NPORTS, 5, number of input FIFOs competing for this output.
- PTR_W, $clog2(NPORTS), width of the round-robin pointer and the grant index.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- fifo_empty  in  NPORTS  empty flag of each input FIFO.
- route_req  in  NPORTS  routing logic: head flit at front of FIFO i targets this output.
- fifo_data  in  NPORTS*WIDTH  front flit of each FIFO (async-read data), port i at [i*WIDTH +: WIDTH].
- fifo_read  out  NPORTS  one-hot pop strobe to the input FIFOs.
- out_full  in  1  downstream FIFO full.
- out_write  out  1  downstream write strobe.
- out_flit  out  WIDTH  flit presented downstream.
- grant_valid  out  1  a packet currently owns the output.
- grant_idx  out  PTR_W  index of the owning input.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0, err=0.
  - fifo_read=0, out_write=0, out_flit=0 (combinational, gated by state).
  - Reset mid-packet drops ownership immediately; no further pops.
- Eligibility:
  - elig[i] = route_req[i] & ~fifo_empty[i] & (type(fifo_data[i]) is head or single).
- State IDLE:
  - Search for the first eligible i, scanning rr_ptr, rr_ptr+1, ... wrapping mod NPORTS.
  - If one is found, register grant_idx=i, grant_valid=1, and go to LOCK.
  - Arbitration latency is 1 cycle. No pop occurs in the IDLE cycle.
- Error detection in IDLE:
  - If any i has route_req[i] & ~fifo_empty[i] with a body or tail front flit, set err=1 (sticky until reset).
  - That port is never granted for that flit.
- State LOCK, with g=grant_idx:
  - xfer = ~fifo_empty[g] & ~out_full.
  - fifo_read[g] = xfer, out_write = xfer, out_flit = fifo_data[g].
  - All combinational, same cycle.
  - An empty FIFO or a full downstream stalls the transfer; the lock is held indefinitely with no timeout.
- Packet end:
  - On an xfer whose flit type is tail or single, the next state is IDLE.
  - grant_valid drops the following cycle.
  - rr_ptr = (g+1) mod NPORTS; wrap from NPORTS-1 to 0.
- A head or single flit arriving mid-LOCK (after the first flit) sets err=1 and is still forwarded.
- route_req and other ports' requests are ignored while in LOCK.
- Throughput:
  - One flit per cycle while locked and not stalled.
  - A 1-cycle bubble follows each packet for re-arbitration.
  - A single-flit packet occupies LOCK for exactly one transfer cycle.
- Grant changes occur only in IDLE; fifo_read is never multi-hot.

Test Plan:
- Reset then single request:
  - Stimulus: port 2 holds a 3-flit packet (head, body, tail), route_req=00100.
  - Required: grant_idx=2 one cycle after request; out_write high for 3 consecutive cycles with flits in order; fifo_read=00100 on those cycles; IDLE after the tail; rr_ptr=3.
- Round-robin fairness:
  - Stimulus: ports 0, 1, 4 each continuously offer single-flit packets, rr_ptr=0.
  - Required: grant order 0, 1, 4, 0, 1, 4; each transfer separated by one idle cycle.
- Wormhole lock:
  - Stimulus: port 3 granted for a 4-flit packet; port 0 requests mid-packet.
  - Required: port 0 is not served until port 3's tail transfers; then port 0 is granted (rr_ptr=4 wraps to 0).
- Backpressure and starvation:
  - Stimulus: out_full=1 for 5 cycles mid-packet, then fifo_empty[g]=1 for 2 cycles.
  - Required: no out_write and no fifo_read during either stall; no flit lost or duplicated; grant_valid stays 1.
- Protocol error:
  - Stimulus: route_req[1]=1 with a body flit at the front in IDLE.
  - Required: err=1 next cycle, port 1 not granted; err persists until rst=0.
- Async reset mid-packet:
  - Stimulus: rst=0 pulsed between clock edges during LOCK.
  - Required: grant_valid, fifo_read and out_write drop to 0 immediately; state=IDLE, rr_ptr=0, err=0 after release.
